sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- N-port round-robin arbiter in front of the single-port SDRAM controller's byte interface (rd/wr/rdy/val/data_rd).
- Lets several requesters (CPU fetch, video, DMA) share one SDRAM.
- Selects one request per controller-ready cycle and returns an accept pulse to that requester.
- Tracks the outstanding read so the read response is routed only to the port that issued it.

Parameters:
- NUM_PORTS, 3, number of requester ports (2..8).
- ADDR_DEPTH, 25, byte address width; matches the controller.
- WDOG_CYCLES, 64, read-response timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- req_rd  in  NUM_PORTS  per-port read request, held until ack.
- req_wr  in  NUM_PORTS  per-port write request, held until ack.
- req_addr  in  NUM_PORTS*ADDR_DEPTH  per-port byte address; port p occupies slice [p*ADDR_DEPTH +: ADDR_DEPTH].
- req_wdata  in  NUM_PORTS*8  per-port write byte.
- req_ack  out  NUM_PORTS  one-hot, one-cycle accept pulse.
- rsp_val  out  NUM_PORTS  one-hot, one-cycle read-data-valid pulse.
- rsp_data  out  8  read byte; valid only where rsp_val is set; 0 otherwise.
- mem_rd  out  1  to controller rd.
- mem_wr  out  1  to controller wr.
- mem_addr  out  ADDR_DEPTH  to controller addr_in.
- mem_wdata  out  8  to controller data_wr.
- mem_rdy  in  1  controller rdy.
- mem_val  in  1  controller val.
- mem_rdata  in  8  controller data_rd.
- wdog_err  out  1  sticky read-timeout flag; exists only with the optional feature.

Behaviour:
- Port p is active when req_rd[p] or req_wr[p] is set. If both are set, the request is treated as a read.
- Selection is combinational and round-robin:
  - The search starts at ptr and takes the first active port from ptr upward, wrapping at NUM_PORTS-1 to 0.
  - ptr resets to 0.
  - On accept, ptr becomes sel+1, wrapping from NUM_PORTS-1 to 0.
- Forwarding to the controller is combinational:
  - mem_rd and mem_wr are asserted only when the grant is enabled (defined below) and some port is selected.
  - mem_addr and mem_wdata are muxed from the selected port, and are 0 when no port is selected.
- Accept condition: grant enabled, mem_rdy=1, and a port selected. In that same cycle req_ack[sel]=1.
  - The requester drops its request (or presents the next one) in the following cycle.
- State machine:
  - ARB_IDLE: grant enabled. On accepting a read, owner<=sel and go to ARB_RD_PEND. An accepted write stays in ARB_IDLE.
  - ARB_RD_PEND: grant enabled only in a cycle where mem_val=1; otherwise grant disabled.
  - In ARB_RD_PEND, on mem_val: rsp_val[owner]=1 and rsp_data=mem_rdata, combinationally, that cycle.
    - If a read is accepted in the same cycle: owner<=new sel, stay in ARB_RD_PEND.
    - Otherwise (write or no accept): go to ARB_IDLE.
  - A read accepted in the same cycle as mem_val never misroutes, because the response uses the registered owner.
- Other boundary rules:
  - mem_val received in ARB_IDLE (spurious) is dropped: rsp_val stays 0.
  - Requests deasserted before ack are simply not served. No request is latched inside the arbiter.
- Reset mid-operation:
  - State returns to ARB_IDLE, ptr and owner go to 0, and all outputs go to 0.
  - A read in flight during reset is lost. The controller is reset together with the arbiter.
- Reset values: req_ack=0, rsp_val=0, rsp_data=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, wdog_err=0.

Optional Feature:
- Macro name: SDRAM_ARB_WATCHDOG_EN.
- When defined:
  - A 16-bit counter clears on entry to ARB_RD_PEND and increments each cycle while in ARB_RD_PEND.
  - If it reaches WDOG_CYCLES, the FSM forces ARB_IDLE and sets wdog_err, which stays set until reset. No rsp_val is issued for that read.
  - A later mem_val arriving in ARB_IDLE is dropped.
- When not defined: no counter and no wdog_err port; ARB_RD_PEND waits for mem_val indefinitely.

Decomposition:
- Package sdram_pkg holds:
  - the arb_state_t enum (ARB_IDLE, ARB_RD_PEND);
  - the SDRAM_BYTE_W=8 constant;
  - the default ADDR_DEPTH constant.
- One sub-module, rr_pick, selects the first active request at or after ptr:
  - input req[NUM_PORTS] and ptr;
  - output sel index and any.
- sdram_arbiter instantiates rr_pick.

Test Plan:
- Single port read: port 1 reads addr 0x0000123 with mem_rdy=1. Expect req_ack=3'b010 that cycle, mem_rd=1, mem_addr=0x0000123. When the model returns mem_val with 0xA5: rsp_val=3'b010, rsp_data=0xA5.
- Round-robin fairness: all 3 ports write continuously with mem_rdy=1 every other cycle. Acks go in order port0, port1, port2, port0, with none repeated until the others are served.
- Back-to-back read overlap: port0 has a read pending; mem_val (0x11) arrives in the same cycle port2's read is accepted. Expect rsp_val=3'b001 with 0x11 that cycle. Port2's later 0x22 appears with rsp_val=3'b100.
- Read/write priority and blocking: port0 has rd and wr both set, so it is treated as a read. While in ARB_RD_PEND with mem_rdy=1 and port1 writing, no ack is given until mem_val arrives.
- Async reset mid-read: assert rst_n=0 between a read accept and its mem_val. All outputs go to 0 immediately. A post-reset mem_val produces no rsp_val.
- Watchdog (macro defined, WDOG_CYCLES=8): read accepted, mem_val never arrives. wdog_err=1 eight cycles after entry; the arbiter is then back in ARB_IDLE and acks a write on the next mem_rdy.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and constants for the SDRAM arbiter slice.
//   arb_state_t     - arbiter FSM states (idle / read response pending)
//   SDRAM_BYTE_W    - controller data width in bits
//   DEF_ADDR_DEPTH  - default controller byte-address width
package sdram_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_RD_PEND
  } arb_state_t;

  localparam int SDRAM_BYTE_W   = 8;
  localparam int DEF_ADDR_DEPTH = 25;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req - per-port active request vector
//   ptr - search start index
//   sel - first active port at or after ptr (wrapping); 0 when none active
//   any - at least one port active
module rr_pick
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [$clog2(NUM_PORTS)-1:0] sel,
  output logic                         any
);

  localparam int PW = $clog2(NUM_PORTS);

  int unsigned idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = i + 32'(ptr);
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!any && req[PW'(idx)]) begin
        any = 1'b1;
        sel = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: N-port round-robin arbiter in front of the SDRAM controller
// byte interface. One request is forwarded per controller-ready cycle; an
// accepted read is tracked so its response returns only to the issuing port.
//   clk, rst_n           - clock, asynchronous active-low reset
//   req_rd/req_wr        - per-port requests, held until req_ack
//   req_addr/req_wdata   - per-port address / write byte (packed per port)
//   req_ack              - one-hot accept pulse
//   rsp_val/rsp_data     - one-hot read-valid pulse and read byte
//   mem_*                - controller side (rd, wr, addr, wdata, rdy, val, rdata)
//   wdog_err             - sticky read-timeout flag (SDRAM_ARB_WATCHDOG_EN only)
// Optional feature macro: SDRAM_ARB_WATCHDOG_EN enables the read-response
// watchdog (WDOG_CYCLES) and the wdog_err port.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS   = 3,
  parameter int ADDR_DEPTH  = DEF_ADDR_DEPTH,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              req_rd,
  input  logic [NUM_PORTS-1:0]              req_wr,
  input  logic [NUM_PORTS*ADDR_DEPTH-1:0]   req_addr,
  input  logic [NUM_PORTS*SDRAM_BYTE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]              req_ack,
  output logic [NUM_PORTS-1:0]              rsp_val,
  output logic [SDRAM_BYTE_W-1:0]           rsp_data,
  output logic                              mem_rd,
  output logic                              mem_wr,
  output logic [ADDR_DEPTH-1:0]             mem_addr,
  output logic [SDRAM_BYTE_W-1:0]           mem_wdata,
  input  logic                              mem_rdy,
  input  logic                              mem_val,
  input  logic [SDRAM_BYTE_W-1:0]           mem_rdata
`ifdef SDRAM_ARB_WATCHDOG_EN
  ,
  output logic                              wdog_err
`endif
);

  localparam int PW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || WDOG_CYCLES < 1) begin : g_param_chk
    $error("sdram_arbiter: NUM_PORTS must be 2..8 and WDOG_CYCLES >= 1");
  end

  arb_state_t           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        owner;
  logic [NUM_PORTS-1:0] act;
  logic [PW-1:0]        sel;
  logic                 any;
  logic                 sel_rd;
  logic                 grant_en;
  logic                 go;
  logic                 accept;
  logic                 rsp_fire;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req (act),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  // Outputs are combinational, so they are also gated by rst_n to read 0
  // for the whole time reset is held, not just after the next edge.
  always_comb begin
    act      = req_rd | req_wr;
    grant_en = rst_n && ((state == ARB_IDLE) || mem_val);
    go       = grant_en && any;
    accept   = go && mem_rdy;
    rsp_fire = rst_n && (state == ARB_RD_PEND) && mem_val;
    sel_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    req_ack   = '0;
    rsp_val   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (rst_n && any && sel == PW'(p)) begin
        sel_rd     = req_rd[p];
        mem_addr   = req_addr[p*ADDR_DEPTH +: ADDR_DEPTH];
        mem_wdata  = req_wdata[p*SDRAM_BYTE_W +: SDRAM_BYTE_W];
        req_ack[p] = accept;
      end
      if (rsp_fire && owner == PW'(p)) rsp_val[p] = 1'b1;
    end
    mem_rd   = go && sel_rd;
    mem_wr   = go && !sel_rd;
    rsp_data = rsp_fire ? mem_rdata : '0;
  end

`ifdef SDRAM_ARB_WATCHDOG_EN
  logic [15:0] wdog_cnt;
  logic        wdog_hit;

  // Hit on the cycle the counter would reach WDOG_CYCLES; a response that
  // arrives in that same cycle still wins.
  always_comb
    wdog_hit = (state == ARB_RD_PEND) && !mem_val &&
               (wdog_cnt == 16'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (accept && sel_rd) wdog_cnt <= '0;
      else if (state == ARB_RD_PEND) wdog_cnt <= wdog_cnt + 16'd1;
      if (wdog_hit) wdog_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      if (accept) ptr <= (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
      if (accept && sel_rd) owner <= sel;
      case (state)
        ARB_IDLE:
          if (accept && sel_rd) state <= ARB_RD_PEND;
        ARB_RD_PEND:
          if (mem_val) state <= (accept && sel_rd) ? ARB_RD_PEND : ARB_IDLE;
`ifdef SDRAM_ARB_WATCHDOG_EN
          else if (wdog_hit) state <= ARB_IDLE;
`endif
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: self-checking bench for sdram_arbiter (3 ports, 25-bit
// addresses). A per-cycle reference model checks every output on the falling
// edge; directed scenarios add literal expectations. With
// SDRAM_ARB_WATCHDOG_EN defined the watchdog scenario (WDOG_CYCLES=8) runs too.
module tb_sdram_arbiter;

  localparam int N  = 3;
  localparam int AD = 25;
  localparam int WD = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_rd = '0, req_wr = '0;
  logic [N*AD-1:0] req_addr = '0;
  logic [N*8-1:0]  req_wdata = '0;
  logic [N-1:0]    req_ack, rsp_val;
  logic [7:0]      rsp_data, mem_wdata;
  logic [7:0]      mem_rdata = '0;
  logic            mem_rd, mem_wr;
  logic            mem_rdy = 1'b0, mem_val = 1'b0;
  logic [AD-1:0]   mem_addr;
`ifdef SDRAM_ARB_WATCHDOG_EN
  logic            wdog_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.NUM_PORTS(N), .ADDR_DEPTH(AD), .WDOG_CYCLES(WD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_val   (rsp_val),
    .rsp_data  (rsp_data),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdy   (mem_rdy),
    .mem_val   (mem_val),
    .mem_rdata (mem_rdata)
`ifdef SDRAM_ARB_WATCHDOG_EN
    ,
    .wdog_err  (wdog_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pointer, pending-read flag and owner as plain integers.
  int m_ptr = 0, m_owner = 0, m_cnt = 0;
  bit m_pend = 0, m_err = 0;
  int nx_ptr = 0, nx_owner = 0, nx_cnt = 0;
  bit nx_pend = 0, nx_err = 0;

  always @(negedge clk) begin : cmp
    int s, p;
    bit acc, is_rd, grant;
    logic [N-1:0]  e_ack, e_rsp;
    logic [7:0]    e_data, e_wdata;
    logic [AD-1:0] e_addr;
    s = -1;
    for (int k = 0; k < N; k++) begin
      p = (m_ptr + k) % N;
      if (s < 0 && (req_rd[p] || req_wr[p])) s = p;
    end
    grant = rst_n && (!m_pend || mem_val) && (s >= 0);
    is_rd = (s >= 0) && req_rd[s];
    acc   = grant && mem_rdy;
    e_ack = '0;
    e_rsp = '0;
    e_addr = '0;
    e_wdata = '0;
    if (acc) e_ack[s] = 1'b1;
    if (rst_n && s >= 0) begin
      e_addr  = req_addr[s*AD +: AD];
      e_wdata = req_wdata[s*8 +: 8];
    end
    e_data = '0;
    if (rst_n && m_pend && mem_val) begin
      e_rsp[m_owner] = 1'b1;
      e_data = mem_rdata;
    end
    check("cyc_req_ack",   32'(req_ack),   32'(e_ack));
    check("cyc_rsp_val",   32'(rsp_val),   32'(e_rsp));
    check("cyc_rsp_data",  32'(rsp_data),  32'(e_data));
    check("cyc_mem_rd",    32'(mem_rd),    32'(grant && is_rd));
    check("cyc_mem_wr",    32'(mem_wr),    32'(grant && !is_rd));
    check("cyc_mem_addr",  32'(mem_addr),  32'(e_addr));
    check("cyc_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
`ifdef SDRAM_ARB_WATCHDOG_EN
    check("cyc_wdog_err",  32'(wdog_err),  32'(rst_n && m_err));
`endif
    nx_ptr = m_ptr; nx_owner = m_owner; nx_pend = m_pend; nx_cnt = m_cnt; nx_err = m_err;
    if (acc) nx_ptr = (s + 1) % N;
    if (m_pend) begin
      if (mem_val) nx_pend = 0;
`ifdef SDRAM_ARB_WATCHDOG_EN
      else begin
        nx_cnt = m_cnt + 1;
        if (nx_cnt == WD) begin
          nx_pend = 0;
          nx_err  = 1;
        end
      end
`endif
    end
    if (acc && is_rd) begin
      nx_pend = 1; nx_owner = s; nx_cnt = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_owner = 0; m_pend = 0; m_cnt = 0; m_err = 0;
    end else begin
      m_ptr = nx_ptr; m_owner = nx_owner; m_pend = nx_pend; m_cnt = nx_cnt; m_err = nx_err;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AD-1:0] a, input logic [7:0] d);
    req_addr[p*AD +: AD] = a;
    req_wdata[p*8 +: 8]  = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rr_tbl [8];

  initial begin
    rr_tbl = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};

    // Reset state: outputs held at 0 even with live inputs.
    req_rd = 3'b001; mem_rdy = 1'b1; mem_val = 1'b1; mem_rdata = 8'hFF;
    set_port(0, 25'h1ABCDEF, 8'h99);
    #2;
    check("rst_ack",   32'(req_ack),  32'h0);
    check("rst_rd",    32'(mem_rd),   32'h0);
    check("rst_addr",  32'(mem_addr), 32'h0);
    check("rst_rsp",   32'(rsp_val),  32'h0);
    check("rst_rdata", 32'(rsp_data), 32'h0);
    step(); step();
    req_rd = '0; mem_val = 1'b0; mem_rdy = 1'b0;
    rst_n = 1'b1;
    step();

    // Single read from port 1.
    req_rd = 3'b010; mem_rdy = 1'b1;
    set_port(1, 25'h0000123, 8'h00);
    #3;
    check("rd1_ack",  32'(req_ack),  32'h2);
    check("rd1_mrd",  32'(mem_rd),   32'h1);
    check("rd1_addr", 32'(mem_addr), 32'h123);
    step();
    req_rd = '0;
    step(); step();
    mem_val = 1'b1; mem_rdata = 8'hA5;
    #3;
    check("rd1_rsp",  32'(rsp_val),  32'h2);
    check("rd1_data", 32'(rsp_data), 32'hA5);
    step();
    mem_val = 1'b0;

    // Round-robin fairness: all ports write, controller ready every other cycle.
    do_reset();
    set_port(0, 25'h10, 8'h10); set_port(1, 25'h20, 8'h20); set_port(2, 25'h30, 8'h30);
    for (int i = 0; i < 8; i++) begin
      req_wr = 3'b111; mem_rdy = (i % 2 == 0);
      #3;
      check("rr_ack", 32'(req_ack), 32'(rr_tbl[i]));
      step();
    end
    req_wr = '0;
    mem_rdy = 1'b1;

    // Back-to-back read overlap: port0 pending, port2 accepted on mem_val.
    req_rd = 3'b001; set_port(0, 25'h40, 8'h00);
    #3;
    check("ov_ack0", 32'(req_ack), 32'h1);
    step();
    req_rd = 3'b100; set_port(2, 25'h1FFFFFF, 8'h00);
    #3;
    check("ov_block", 32'(req_ack),  32'h0);
    check("ov_mrd0",  32'(mem_rd),   32'h0);
    check("ov_addr",  32'(mem_addr), 32'h1FFFFFF);
    step();
    mem_val = 1'b1; mem_rdata = 8'h11;
    #3;
    check("ov_rsp0",  32'(rsp_val),  32'h1);
    check("ov_data0", 32'(rsp_data), 32'h11);
    check("ov_ack2",  32'(req_ack),  32'h4);
    check("ov_mrd2",  32'(mem_rd),   32'h1);
    step();
    req_rd = '0; mem_val = 1'b0;
    step();
    mem_val = 1'b1; mem_rdata = 8'h22;
    #3;
    check("ov_rsp2",  32'(rsp_val),  32'h4);
    check("ov_data2", 32'(rsp_data), 32'h22);
    step();
    mem_val = 1'b0;

    // rd+wr treated as read; pending read blocks a write until mem_val.
    req_rd = 3'b001; req_wr = 3'b011; set_port(1, 25'h50, 8'h5C);
    #3;
    check("pri_mrd", 32'(mem_rd),  32'h1);
    check("pri_mwr", 32'(mem_wr),  32'h0);
    check("pri_ack", 32'(req_ack), 32'h1);
    step();
    req_rd = '0; req_wr = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("blk_ack", 32'(req_ack), 32'h0);
      step();
    end
    mem_val = 1'b1; mem_rdata = 8'h33;
    #3;
    check("blk_ack1", 32'(req_ack), 32'h2);
    check("blk_mwr",  32'(mem_wr),  32'h1);
    check("blk_rsp",  32'(rsp_val), 32'h1);
    step();
    req_wr = '0; mem_val = 1'b0;

    // Spurious mem_val while idle is dropped.
    mem_val = 1'b1; mem_rdata = 8'h5A;
    #3;
    check("spur_rsp",  32'(rsp_val),  32'h0);
    check("spur_data", 32'(rsp_data), 32'h0);
    step();
    mem_val = 1'b0;

    // Async reset between a read accept and its response.
    req_rd = 3'b010; set_port(1, 25'h0ABCDE, 8'h00);
    #3;
    check("ar_ack", 32'(req_ack), 32'h2);
    step();
    req_rd = '0;
    step();
    set_port(2, 25'h77, 8'h7E);
    mem_val = 1'b1; mem_rdata = 8'h77; req_wr = 3'b100;
    #1;
    check("ar_pre_rsp", 32'(rsp_val), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_rsp",  32'(rsp_val),  32'h0);
    check("ar_data", 32'(rsp_data), 32'h0);
    check("ar_ack0", 32'(req_ack),  32'h0);
    check("ar_mwr",  32'(mem_wr),   32'h0);
    check("ar_addr", 32'(mem_addr), 32'h0);
    step(); step();
    rst_n = 1'b1;
    #3;
    check("ar_post_rsp", 32'(rsp_val), 32'h0);
    check("ar_post_ack", 32'(req_ack), 32'h4);
    step();
    req_wr = '0; mem_val = 1'b0;

`ifdef SDRAM_ARB_WATCHDOG_EN
    // Watchdog: read never answered; flag after WD cycles, then a write is served.
    do_reset();
    mem_rdy = 1'b1;
    req_rd = 3'b001;
    #3;
    check("wd_ack0", 32'(req_ack), 32'h1);
    step();
    req_rd = '0; req_wr = 3'b010;
    #3;
    check("wd_err_early", 32'(wdog_err), 32'h0);
    check("wd_block",     32'(req_ack),  32'h0);
    step();
    for (int i = 1; i < WD; i++) begin
      #3;
      check("wd_err_early", 32'(wdog_err), 32'h0);
      check("wd_block",     32'(req_ack),  32'h0);
      step();
    end
    #3;
    check("wd_err",  32'(wdog_err), 32'h1);
    check("wd_ack1", 32'(req_ack),  32'h2);
    step();
    req_wr = '0; mem_val = 1'b1; mem_rdata = 8'hEE;
    #3;
    check("wd_late_rsp", 32'(rsp_val),  32'h0);
    check("wd_sticky",   32'(wdog_err), 32'h1);
    step();
    mem_val = 1'b0;
`endif

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
